// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_e;

    // Iteration counter width for a given binary input width.
    function automatic int unsigned cnt_w(input int unsigned bin_w);
        return $clog2(bin_w + 1);
    endfunction

    // Counter width for the default 8-bit input.
    localparam int unsigned CNT_W = cnt_w(8);

    // Largest value representable in the given number of BCD digits.
    function automatic longint unsigned pow10_minus1(input int unsigned digits);
        longint unsigned p;
        p = 1;
        for (int unsigned k = 0; k < digits; k++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and data bus of the binary-to-BCD converter.
interface bin2bcd_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bcd_dig_adj.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_dig_adj (
    input  logic [3:0] dig_i,
    output logic [3:0] dig_o
);
    // 4-bit add, no carry out: inputs 5..15 wrap within the digit.
    always_comb dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one bit per clock.
// Result and overflow are registered and held until the next conversion
// completes, so downstream seven-segment decoders see a stable bus.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  bus
);
    localparam int unsigned CNT_BITS = cnt_w(BIN_W);
    localparam int unsigned SCR_W    = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_FIN   = FIN;

    logic [1:0]          state_q,   state_d;
    logic [CNT_BITS-1:0] cnt_q,     cnt_d;
    logic [BIN_W-1:0]    shreg_q,   shreg_d;
    logic [SCR_W-1:0]    scr_q,     scr_d;
    logic                ovf_scr_q, ovf_scr_d;
    logic [SCR_W-1:0]    bcd_q,     bcd_d;
    logic                ovf_q,     ovf_d;

    logic [SCR_W-1:0]    adj;
    logic [SCR_W-1:0]    scr_shift;
    logic                top_bit;
    logic                accept;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_dig_adj u_adj (
            .dig_i (scr_q[4*g +: 4]),
            .dig_o (adj[4*g +: 4])
        );
    end

    // Adjusted scratch shifted left by one, binary MSB entering digit 0.
    always_comb begin
        {top_bit, scr_shift} = {adj, shreg_q[BIN_W-1]};
    end

    // A new request is taken only when idle or in the single done cycle.
    always_comb begin
        accept = bus.start && ((state_q == S_IDLE) || (state_q == S_FIN));
    end

    // Next-state logic for control, scratch and held result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scr_d     = scr_q;
        ovf_scr_d = ovf_scr_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_SHIFT: begin
                scr_d     = scr_shift;
                shreg_d   = shreg_q << 1;
                ovf_scr_d = ovf_scr_q | top_bit;
                cnt_d     = cnt_q - CNT_BITS'(1);
                if (cnt_q == CNT_BITS'(1)) begin
                    // Final iteration result goes straight to the output,
                    // including the bit shifted out on this very edge.
                    bcd_d   = scr_shift;
                    ovf_d   = ovf_scr_q | top_bit;
                    state_d = S_FIN;
                end
            end
            default: begin
                if (accept) begin
                    shreg_d   = bus.bin;
                    scr_d     = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = CNT_BITS'(BIN_W);
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scr_q     <= '0;
            ovf_scr_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scr_q     <= scr_d;
            ovf_scr_q <= ovf_scr_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    // Status decoded from state; result driven from the held registers.
    always_comb begin
        bus.busy     = (state_q == S_SHIFT);
        bus.done     = (state_q == S_FIN);
        bus.bcd      = bcd_q;
        bus.overflow = ovf_q;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance,
// driven with directed and random values and checked against an
// arithmetic decimal model.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int unsigned BW = 8;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_if #(.BIN_W(BW), .DIGITS(3)) bus_a ();
    bin2bcd_if #(.BIN_W(BW), .DIGITS(2)) bus_b ();

    bin2bcd_seq #(.BIN_W(BW), .DIGITS(3)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    bin2bcd_seq #(.BIN_W(BW), .DIGITS(2)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    int errors = 0;
    int checks = 0;
    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: digits of v mod 10^digits, overflow if v too large.
    function automatic exp_t model(input int unsigned v, input int unsigned digits);
        exp_t e;
        longint unsigned p;
        e.bcd = '0;
        e.cyc = 0;
        e.ovf = (longint'(v) > pow10_minus1(digits));
        p = 1;
        for (int unsigned k = 0; k < digits; k++) begin
            e.bcd[4*k +: 4] = 4'((longint'(v) / p) % 10);
            p = p * 10;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic [11:0] hold[2];
    logic        hovf[2];
    logic        prst[2]  = '{1'b1, 1'b1};
    logic        pdone[2] = '{1'b0, 1'b0};

    task automatic mon(input int id, input logic r, input logic busy, input logic done,
                       input logic [11:0] bcd, input logic ovf, input int unsigned digits);
        exp_t e;
        if (prst[id]) begin
            hold[id] = '0;
            hovf[id] = 1'b0;
        end
        prst[id] = r;
        if (r) begin
            pdone[id] = 1'b0;
            return;
        end
        if (pdone[id]) chk("done_one_cycle", 32'(done), 32'd0);
        pdone[id] = done;
        if (done) begin
            chk("busy_with_done", 32'(busy), 32'd0);
            if ((id == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: dut%0d got done=1 expected no pending result", id);
                hold[id] = bcd;
                hovf[id] = ovf;
            end else begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                chk("bcd", 32'(bcd), 32'(e.bcd));
                chk("overflow", 32'(ovf), 32'(e.ovf));
                chk("done_latency", cyc, e.cyc);
                for (int unsigned k = 0; k < digits; k++)
                    chk("digit_range", 32'(bcd[4*k +: 4] <= 4'd9), 32'd1);
                hold[id] = e.bcd;
                hovf[id] = e.ovf;
            end
        end else begin
            chk("bcd_stable", 32'(bcd), 32'(hold[id]));
            chk("ovf_stable", 32'(ovf), 32'(hovf[id]));
        end
    endtask

    always @(negedge clk) mon(0, rst_a, bus_a.busy, bus_a.done, bus_a.bcd, bus_a.overflow, 3);
    always @(negedge clk) mon(1, rst_b, bus_b.busy, bus_b.done, 12'(bus_b.bcd), bus_b.overflow, 2);

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int id, input logic s, input logic [BW-1:0] v);
        if (id == 0) begin
            bus_a.start = s;
            bus_a.bin   = v;
        end else begin
            bus_b.start = s;
            bus_b.bin   = v;
        end
    endtask

    function automatic logic is_busy(input int id);
        return (id == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic is_done(input int id);
        return (id == 0) ? bus_a.done : bus_b.done;
    endfunction

    task automatic push(input int id, input int unsigned v);
        exp_t e;
        e = model(v, (id == 0) ? 3 : 2);
        e.cyc = cyc + BW + 1;
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        while (is_busy(id) && n < 100) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic wait_done(input int id);
        int n = 0;
        while (!is_done(id) && n < 100) begin
            tick();
            n++;
        end
        chk("done_timeout", 32'(n < 100), 32'd1);
    endtask

    // Request a conversion; returns one tick after the accepting edge.
    task automatic convert(input int id, input int unsigned v, input bit expect_result);
        wait_ready(id);
        drive(id, 1'b1, BW'(v));
        if (expect_result) push(id, v);
        tick();
        drive(id, 1'b0, BW'($urandom));
    endtask

    task automatic seq_a();
        int n;
        // zero, with busy duration
        convert(0, 0, 1);
        n = 0;
        while (bus_a.busy && n < 50) begin
            n++;
            tick();
        end
        chk("busy_cycles", n, 8);
        convert(0, 255, 1);
        convert(0, 123, 1);
        convert(0, 9, 1);
        // start during SHIFT ignored; start in FIN accepted back-to-back
        convert(0, 42, 1);
        tick();
        tick();
        drive(0, 1'b1, 8'd77);
        tick();
        drive(0, 1'b0, 8'd0);
        wait_done(0);
        drive(0, 1'b1, 8'd77);
        push(0, 77);
        tick();
        chk("b2b_busy", 32'(bus_a.busy), 32'd1);
        drive(0, 1'b0, 8'd0);
        // reset mid-conversion
        convert(0, 255, 1);
        wait_done(0);
        convert(0, 17, 0);
        tick();
        tick();
        tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("abort_busy", 32'(bus_a.busy), 32'd0);
        chk("abort_done", 32'(bus_a.done), 32'd0);
        chk("abort_bcd", 32'(bus_a.bcd), 32'd0);
        chk("abort_ovf", 32'(bus_a.overflow), 32'd0);
        tick();
        tick();
        convert(0, 17, 1);
        wait_done(0);
        // exhaustive sweep
        for (int unsigned v = 0; v < 256; v++) convert(0, v, 1);
    endtask

    task automatic seq_b();
        convert(1, 200, 1);
        convert(1, 99, 1);
        convert(1, 100, 1);
        for (int i = 0; i < 60; i++) begin
            convert(1, $urandom_range(0, 255), 1);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0;
        bus_a.bin   = '0;
        bus_b.start = 1'b0;
        bus_b.bin   = '0;
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("reset_busy", 32'(bus_a.busy), 32'd0);
        chk("reset_done", 32'(bus_a.done), 32'd0);
        chk("reset_bcd", 32'(bus_a.bcd), 32'd0);
        chk("reset_ovf", 32'(bus_a.overflow), 32'd0);
        chk("reset_bcd_b", 32'(bus_b.bcd), 32'd0);
        fork
            seq_a();
            seq_b();
        join
        for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        tick();
        chk("queue_drained", qa.size() + qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Iterative shift-add-3 (double-dabble) converter from unsigned binary to packed BCD digits. Sits directly upstream of the per-digit BCD-to-seven-segment decoders and drives their 4-bit inputs from a registered, stable BCD bus. It uses a start/busy/done handshake, takes one iteration per clock, and holds its output between conversions so the display never flickers.

Parameters:
BIN_W, 8, width of the binary input in bits (>=1)
DIGITS, 3, number of BCD digits produced (>=1)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a conversion of bin; sampled only when ready
bin  input  BIN_W  unsigned binary value; sampled on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse; bcd/overflow updated on this cycle
bcd  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], digit 0 is least significant
overflow  output  1  last result exceeded 10^DIGITS-1; bcd then holds value mod 10^DIGITS

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal scratch=0, iteration counter=0.
- Reset mid-conversion aborts it. bcd and overflow return to 0. No done pulse is issued.
- States:
  - IDLE: ready; busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - FIN: busy=0, done=1.
- Accept: on an edge where start=1 and state is IDLE or FIN:
  - latch bin into the shift register and clear the BCD scratch;
  - set the sticky overflow scratch to 0;
  - set cnt=BIN_W and go to SHIFT.
- Start in SHIFT is ignored. It is not queued, and bin is not resampled.
- Each SHIFT edge:
  - every scratch digit >=5 gets +3 (4-bit, no carry between digits);
  - then {scratch, shreg} shifts left one bit, with the MSB of shreg entering digit 0 bit 0;
  - the bit shifted out of the top digit's MSB ORs into overflow scratch;
  - cnt decrements by 1.
- When an edge processes the iteration with cnt==1, that same edge registers bcd<=new scratch, overflow<=overflow scratch (including this iteration's shifted-out bit), and state<=FIN.
- Latency: start accepted at edge E0 -> done high during the cycle after edge E0+BIN_W. That is BIN_W+1 clocks from start high to done high.
- FIN lasts exactly one cycle, then goes to IDLE, unless start=1 is accepted (back-to-back conversion).
- Throughput: one conversion per BIN_W+1 cycles.
- bcd and overflow change only on the FIN entry edge or on reset. They are stable during SHIFT and IDLE.
- Every output digit is in 0..9 for all inputs, including overflow cases.
- Digit arithmetic is 4-bit unsigned. The adjust is applied before the shift, never after the final shift.
- BIN_W=1 edge case: a single SHIFT cycle.
- done and busy are never high together.

Decomposition:
- Package bin2bcd_pkg holds:
  - state enum {IDLE, SHIFT, FIN};
  - constant CNT_W = clog2(BIN_W+1);
  - function pow10_minus1 for the bench.
- One combinational sub-module, bcd_dig_adj: 4-bit in, 4-bit out, out = in>=5 ? in+3 : in. It is instantiated DIGITS times per iteration.

Test Plan:
- rst, then start with bin=0 -> done after 9 cycles, bcd=12'h000, overflow=0; busy high for 8 cycles.
- bin=255 (BIN_W=8, DIGITS=3) -> bcd=12'h255, overflow=0. Also bin=123 -> 12'h123, and bin=9 -> 12'h009.
- Parameter override DIGITS=2:
  - bin=200 -> bcd=8'h00, overflow=1;
  - bin=99 -> 8'h99, overflow=0;
  - bin=100 -> 8'h00, overflow=1.
- Start with bin=42, then pulse start with bin=77 on cycle 3 of SHIFT -> ignored; result is 12'h042. A fresh start held high during the FIN cycle with bin=77 -> accepted back-to-back, yielding 12'h077 nine cycles later.
- Complete conversion of 255, then start 17 and assert rst on cycle 4 -> bcd=0, overflow=0, busy=0, and no done pulse. A subsequent start with bin=17 -> 12'h017.
- Exhaustive sweep of bin 0..255 against a reference model -> every digit in 0..9, done pulse exactly one cycle, and bcd stable between pulses.
